branch_resolver: RTL

//   EX-stage counterpart of the BTB predictor: checks the prediction that travelled down
//   the pipe (bp_to_ex_bus) against the real branch outcome computed in EX. On a mismatch
//   it emits the redirect/training bus br_bus {br_e, br_target}, which restarts fetch and

---
 rtl/branch_resolver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// ----------------------------------------------------------------------------
// branch_resolver
//   EX-stage check of the fetch-time BTB prediction against the resolved branch
//   outcome. On a mismatch it raises the redirect/training bus {br_e, br_target}
//   combinationally in the same cycle. A one-shot flag keeps a stalled
//   instruction from redirecting more than once. Saturating counters track
//   resolved branches and issued redirects.
//
// Ports
//   clk                 clock
//   rst                 synchronous, active-high reset
//   i_stall[5:0]        pipeline stall vector; bit 3 set = EX held
//   i_flush             exception flush, kills the EX instruction
//   i_ex_valid          EX holds a real instruction (not a bubble)
//   i_ex_pc[31:0]       PC of the EX instruction
//   i_ex_is_branch      EX instruction is a branch/jump
//   i_ex_taken          resolved direction (1 = taken)
//   i_ex_target[31:0]   resolved taken target
//   i_bp_to_ex_bus[32:0] {bp_e, bp_target} prediction carried from fetch
//   o_br_bus[32:0]      {br_e, br_target} redirect + BTB training request
//   o_cnt_branch        branches resolved (saturating)
//   o_cnt_mispredict    redirects issued (saturating)
// ----------------------------------------------------------------------------
module branch_resolver #(
    parameter int unsigned FALL_OFS = 8,
    parameter int unsigned SEQ_OFS  = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       i_stall,
    input  logic             i_flush,
    input  logic             i_ex_valid,
    input  logic [31:0]      i_ex_pc,
    input  logic             i_ex_is_branch,
    input  logic             i_ex_taken,
    input  logic [31:0]      i_ex_target,
    input  logic [32:0]      i_bp_to_ex_bus,
    output logic [32:0]      o_br_bus,
    output logic [CNT_W-1:0] o_cnt_branch,
    output logic [CNT_W-1:0] o_cnt_mispredict
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             r_fired;
    logic [CNT_W-1:0] r_cnt_branch;
    logic [CNT_W-1:0] r_cnt_mispredict;

    logic             w_stop;
    logic             w_chk;
    logic             w_bp_e;
    logic [31:0]      w_bp_target;
    logic             w_m1;
    logic             w_m2;
    logic             w_m3;
    logic             w_m4;
    logic             w_br_e;
    logic [31:0]      w_br_target;
    logic             w_retire;
    logic             w_redirected;
    logic             w_unused_stall;

    // Only the EX hold bit matters here.
    assign w_stop         = i_stall[3];
    assign w_unused_stall = ^{i_stall[5:4], i_stall[2:0]};

    assign w_bp_e      = i_bp_to_ex_bus[32];
    assign w_bp_target = i_bp_to_ex_bus[31:0];

    // Gating on rst keeps the bus quiet during reset.
    assign w_chk = ~rst & i_ex_valid & ~i_flush & ~r_fired;

    assign w_m1 = i_ex_is_branch & i_ex_taken & ~w_bp_e;
    assign w_m2 = i_ex_is_branch & i_ex_taken & w_bp_e & (w_bp_target != i_ex_target);
    assign w_m3 = i_ex_is_branch & ~i_ex_taken & w_bp_e;
    assign w_m4 = ~i_ex_is_branch & w_bp_e;

    always_comb begin
        w_br_e      = 1'b0;
        w_br_target = 32'h0;
        if (w_chk) begin
            if (w_m1 | w_m2) begin
                w_br_e      = 1'b1;
                w_br_target = i_ex_target;
            end else if (w_m3) begin
                w_br_e      = 1'b1;
                w_br_target = i_ex_pc + 32'(FALL_OFS);
            end else if (w_m4) begin
                w_br_e      = 1'b1;
                w_br_target = i_ex_pc + 32'(SEQ_OFS);
            end
        end
    end

    assign o_br_bus = {w_br_e, w_br_target};

    // Fired holds across a stall so a held instruction redirects only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fired <= 1'b0;
        end else if (i_flush) begin
            r_fired <= 1'b0;
        end else if (w_br_e && w_stop) begin
            r_fired <= 1'b1;
        end else if (!w_stop) begin
            r_fired <= 1'b0;
        end
    end

    // Counting happens on the cycle the instruction leaves EX.
    assign w_retire     = i_ex_valid & ~i_flush & ~w_stop;
    assign w_redirected = w_br_e | r_fired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_branch     <= '0;
            r_cnt_mispredict <= '0;
        end else if (w_retire) begin
            if (i_ex_is_branch && (r_cnt_branch != CntMax)) begin
                r_cnt_branch <= r_cnt_branch + CNT_W'(1);
            end
            if (w_redirected && (r_cnt_mispredict != CntMax)) begin
                r_cnt_mispredict <= r_cnt_mispredict + CNT_W'(1);
            end
        end
    end

    assign o_cnt_branch     = r_cnt_branch;
    assign o_cnt_mispredict = r_cnt_mispredict;

endmodule
